// File: rtl/cpu_pkg.sv
// Shared cpu4 pipeline types: hazard controller states and forwarding select encodings.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } hz_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_S4 = 2'b01;
  localparam fwd_sel_t FWD_S5 = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX-stage operand forwarding select for one source register; the younger result (s4) wins.
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_BITS = 5
) (
  input  logic [REG_ADDR_BITS-1:0] src_addr,
  input  logic [REG_ADDR_BITS-1:0] waddr_s4,
  input  logic [REG_ADDR_BITS-1:0] waddr_s5,
  input  logic                     rw_s4,
  input  logic                     rw_s5,
  output logic [1:0]               sel
);

  always_comb begin
    sel = FWD_RF;
    if (!rw_s4 && (waddr_s4 != '0) && (waddr_s4 == src_addr)) begin
      sel = FWD_S4;
    end else if (!rw_s5 && (waddr_s5 != '0) && (waddr_s5 == src_addr)) begin
      sel = FWD_S5;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// cpu4 pipeline hazard controller: load-use stalls, branch squash, forwarding, halt drain.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
//
// state    | meaning
// RUN      | normal issue; hazards/branches/halt resolved combinationally
// LD_STALL | extra load-use stall cycles counted down in ld_cnt
// DRAIN    | halt seen in decode, waiting for it to reach writeback
// HALTED   | pipe drained, frozen until reset
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_BITS = 5,
  parameter int LOAD_LAT      = 1,
  parameter int CNT_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [REG_ADDR_BITS-1:0] r1_addr,
  input  logic [REG_ADDR_BITS-1:0] r2_addr,
  input  logic                     use_r1,
  input  logic                     use_r2,
  input  logic [REG_ADDR_BITS-1:0] r1_addr_s3,
  input  logic [REG_ADDR_BITS-1:0] r2_addr_s3,
  input  logic [REG_ADDR_BITS-1:0] waddr_s3,
  input  logic [REG_ADDR_BITS-1:0] waddr_s4,
  input  logic [REG_ADDR_BITS-1:0] waddr_s5,
  input  logic                     rw_s3,
  input  logic                     rw_s4,
  input  logic                     rw_s5,
  input  logic                     sel_mem_s3,
  input  logic                     take_br,
  input  logic                     halt_s2,
  input  logic                     halt_s5,
  output logic                     stall_pipe,
  output logic                     bubble_id_ex,
  output logic                     flush_if,
  output logic [1:0]               fwd_r1_sel,
  output logic [1:0]               fwd_r2_sel,
  output logic                     halted,
  output logic [CNT_BITS-1:0]      stall_cnt,
  output logic [CNT_BITS-1:0]      flush_cnt
);

  localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);

  hz_state_t  state, state_nxt;
  logic [2:0] ld_cnt, ld_cnt_nxt;
  logic       hz;

  assign hz = sel_mem_s3 && !rw_s3 && (waddr_s3 != '0) &&
              ((use_r1 && (r1_addr == waddr_s3)) || (use_r2 && (r2_addr == waddr_s3)));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state  <= RUN;
      ld_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ld_cnt_nxt   = ld_cnt;
    stall_pipe   = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if     = 1'b0;
    halted       = 1'b0;
    case (state)
      RUN: begin
        if (halt_s2) begin
          stall_pipe = 1'b1;
          state_nxt  = DRAIN;
        end else if (hz) begin
          stall_pipe   = 1'b1;
          bubble_id_ex = 1'b1;
          if (LOAD_LAT > 1) begin
            ld_cnt_nxt = LD_INIT;
            state_nxt  = LD_STALL;
          end
        end else if (take_br) begin
          // a branch held behind a stall gets here on its first free cycle
          flush_if = 1'b1;
        end
      end
      LD_STALL: begin
        stall_pipe   = 1'b1;
        bubble_id_ex = 1'b1;
        ld_cnt_nxt   = ld_cnt - 3'd1;
        if (ld_cnt <= 3'd1) begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        stall_pipe   = 1'b1;
        bubble_id_ex = 1'b1;
        if (halt_s5) begin
          state_nxt = HALTED;
        end
      end
      HALTED: begin
        stall_pipe   = 1'b1;
        bubble_id_ex = 1'b1;
        halted       = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  fwd_sel #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_fwd_r1 (
    .src_addr (r1_addr_s3),
    .waddr_s4 (waddr_s4),
    .waddr_s5 (waddr_s5),
    .rw_s4    (rw_s4),
    .rw_s5    (rw_s5),
    .sel      (fwd_r1_sel)
  );

  fwd_sel #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_fwd_r2 (
    .src_addr (r2_addr_s3),
    .waddr_s4 (waddr_s4),
    .waddr_s5 (waddr_s5),
    .rw_s4    (rw_s4),
    .rw_s5    (rw_s5),
    .sel      (fwd_r2_sel)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_BITS-1:0] stall_q, flush_q;

  // halt/drain stall cycles are deliberately excluded from stall_cnt
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_pipe && ((state == RUN) || (state == LD_STALL)) && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_BITS'(1);
      end
      if (flush_if && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_BITS'(1);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus.
module tb_hazard_ctrl;
  import cpu_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] r1, r2;
    logic       u1, u2;
    logic [4:0] r1s3, r2s3, w3, w4, w5;
    logic       rw3, rw4, rw5, mem3, br, h2, h5;
  } in_t;

  typedef struct packed {
    logic       stall, bubble, flush, hlt;
    logic [1:0] f1, f2;
  } out_t;

  typedef struct packed {
    in_t       in;
    out_t      e1;
    out_t      e3;
    hz_state_t st3;
  } step_t;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  in_t  din;
  int   n_checks = 0;
  int   n_err = 0;
  step_t sb[$];

  logic        stall1, bubble1, flush1, halted1, stall3, bubble3, flush3, halted3;
  logic [1:0]  f1_1, f2_1, f1_3, f2_3;
  logic [15:0] sc1, fc1, sc3, fc3;
  out_t        o1, o3;

  assign o1 = {stall1, bubble1, flush1, halted1, f1_1, f2_1};
  assign o3 = {stall3, bubble3, flush3, halted3, f1_3, f2_3};

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_BITS(5), .LOAD_LAT(1), .CNT_BITS(16)) dut1 (
    .clk(clk), .rst_(rst_), .r1_addr(din.r1), .r2_addr(din.r2), .use_r1(din.u1), .use_r2(din.u2),
    .r1_addr_s3(din.r1s3), .r2_addr_s3(din.r2s3), .waddr_s3(din.w3), .waddr_s4(din.w4),
    .waddr_s5(din.w5), .rw_s3(din.rw3), .rw_s4(din.rw4), .rw_s5(din.rw5), .sel_mem_s3(din.mem3),
    .take_br(din.br), .halt_s2(din.h2), .halt_s5(din.h5), .stall_pipe(stall1),
    .bubble_id_ex(bubble1), .flush_if(flush1), .fwd_r1_sel(f1_1), .fwd_r2_sel(f2_1),
    .halted(halted1), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_ctrl #(.REG_ADDR_BITS(5), .LOAD_LAT(3), .CNT_BITS(16)) dut3 (
    .clk(clk), .rst_(rst_), .r1_addr(din.r1), .r2_addr(din.r2), .use_r1(din.u1), .use_r2(din.u2),
    .r1_addr_s3(din.r1s3), .r2_addr_s3(din.r2s3), .waddr_s3(din.w3), .waddr_s4(din.w4),
    .waddr_s5(din.w5), .rw_s3(din.rw3), .rw_s4(din.rw4), .rw_s5(din.rw5), .sel_mem_s3(din.mem3),
    .take_br(din.br), .halt_s2(din.h2), .halt_s5(din.h5), .stall_pipe(stall3),
    .bubble_id_ex(bubble3), .flush_if(flush3), .fwd_r1_sel(f1_3), .fwd_r2_sel(f2_3),
    .halted(halted3), .stall_cnt(sc3), .flush_cnt(fc3));

  function automatic in_t idle();
    in_t s;
    s = '0;
    s.rw3 = 1'b1;
    s.rw4 = 1'b1;
    s.rw5 = 1'b1;
    return s;
  endfunction

  // load in EX writing r, decode consumer reading r as its first operand
  function automatic in_t with_hz(in_t s0, logic [4:0] r);
    in_t s;
    s = s0;
    s.mem3 = 1'b1;
    s.rw3 = 1'b0;
    s.w3 = r;
    s.r1 = r;
    s.u1 = 1'b1;
    return s;
  endfunction

  function automatic out_t eo(logic s, logic b, logic f, logic h, logic [1:0] a, logic [1:0] c);
    return {s, b, f, h, a, c};
  endfunction

  task automatic do_reset();
    din = idle();
    #1 rst_ = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({o1, o3, dut3.state, dut3.ld_cnt, dut1.state} !== {16'h0, RUN, 3'd0, RUN}) begin
      n_err++;
      $display("FAIL reset_outputs: got %b %b st=%0d ld=%0d, expected all zero, RUN", o1, o3, dut3.state, dut3.ld_cnt);
    end
    n_checks++;
    if ({sc1, fc1, sc3, fc3} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_counters: got %0d %0d %0d %0d, expected 0", sc1, fc1, sc3, fc3);
    end
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_load_use();
    step_t t[$];
    step_t e;
    in_t s;
    do_reset();
    t.push_back('{with_hz(idle(), 5'd3), eo(1,1,0,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), RUN});
    s = idle(); s.rw4 = 1'b0; s.w4 = 5'd3;
    t.push_back('{s, eo(0,0,0,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), LD_STALL});
    s = idle(); s.rw5 = 1'b0; s.w5 = 5'd3; s.r1s3 = 5'd3;
    t.push_back('{s, eo(0,0,0,0,2'b10,2'b00), eo(1,1,0,0,2'b10,2'b00), LD_STALL});
    t.push_back('{idle(), eo(0,0,0,0,2'b00,2'b00), eo(0,0,0,0,2'b00,2'b00), RUN});
    foreach (t[i]) begin
      @(posedge clk); #1 din = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({o1, o3, dut3.state} !== {e.e1, e.e3, e.st3}) begin
        n_err++;
        $display("FAIL load_use[%0d]: got %b %b st3=%0d, expected %b %b st3=%0d", i, o1, o3, dut3.state, e.e1, e.e3, e.st3);
      end
    end
    n_checks++;
    if ({sc1, fc1, sc3, fc3} !== {(PERF ? 16'd1 : 16'd0), 16'd0, (PERF ? 16'd3 : 16'd0), 16'd0}) begin
      n_err++;
      $display("FAIL load_use_cnt: got stall %0d/%0d flush %0d/%0d, expected stall %0d/%0d flush 0/0", sc1, sc3, fc1, fc3, PERF ? 1 : 0, PERF ? 3 : 0);
    end
  endtask

  task automatic test_no_hazard();
    step_t t[$];
    step_t e;
    in_t s;
    do_reset();
    s = with_hz(idle(), 5'd0); s.r2 = 5'd0; s.u2 = 1'b1; s.rw4 = 1'b0; s.rw5 = 1'b0;
    t.push_back('{s, eo(0,0,0,0,2'b00,2'b00), eo(0,0,0,0,2'b00,2'b00), RUN});
    s = with_hz(idle(), 5'd4); s.rw3 = 1'b1;
    t.push_back('{s, eo(0,0,0,0,2'b00,2'b00), eo(0,0,0,0,2'b00,2'b00), RUN});
    s = with_hz(idle(), 5'd4); s.r2 = 5'd4; s.u1 = 1'b0;
    t.push_back('{s, eo(0,0,0,0,2'b00,2'b00), eo(0,0,0,0,2'b00,2'b00), RUN});
    s = with_hz(idle(), 5'd4); s.mem3 = 1'b0;
    t.push_back('{s, eo(0,0,0,0,2'b00,2'b00), eo(0,0,0,0,2'b00,2'b00), RUN});
    s = with_hz(idle(), 5'd5); s.u1 = 1'b0; s.r2 = 5'd5; s.u2 = 1'b1;
    t.push_back('{s, eo(1,1,0,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), RUN});
    t.push_back('{idle(), eo(0,0,0,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), LD_STALL});
    t.push_back('{idle(), eo(0,0,0,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), LD_STALL});
    t.push_back('{idle(), eo(0,0,0,0,2'b00,2'b00), eo(0,0,0,0,2'b00,2'b00), RUN});
    foreach (t[i]) begin
      @(posedge clk); #1 din = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({o1, o3, dut3.state} !== {e.e1, e.e3, e.st3}) begin
        n_err++;
        $display("FAIL no_hazard[%0d]: got %b %b st3=%0d, expected %b %b st3=%0d", i, o1, o3, dut3.state, e.e1, e.e3, e.st3);
      end
    end
  endtask

  task automatic test_forwarding();
    step_t t[$];
    step_t e;
    in_t s;
    s = idle(); s.rw4 = 1'b0; s.w4 = 5'd7; s.rw5 = 1'b0; s.w5 = 5'd7; s.r2s3 = 5'd7;
    t.push_back('{s, eo(0,0,0,0,2'b00,2'b01), eo(0,0,0,0,2'b00,2'b01), RUN});
    s.rw4 = 1'b1;
    t.push_back('{s, eo(0,0,0,0,2'b00,2'b10), eo(0,0,0,0,2'b00,2'b10), RUN});
    s.rw4 = 1'b0; s.rw5 = 1'b1; s.r1s3 = 5'd7;
    t.push_back('{s, eo(0,0,0,0,2'b01,2'b01), eo(0,0,0,0,2'b01,2'b01), RUN});
    s = idle(); s.rw4 = 1'b0; s.rw5 = 1'b0;
    t.push_back('{s, eo(0,0,0,0,2'b00,2'b00), eo(0,0,0,0,2'b00,2'b00), RUN});
    s.w4 = 5'd9; s.r1s3 = 5'd9; s.w5 = 5'd2; s.r2s3 = 5'd2;
    t.push_back('{s, eo(0,0,0,0,2'b01,2'b10), eo(0,0,0,0,2'b01,2'b10), RUN});
    foreach (t[i]) begin
      @(posedge clk); #1 din = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({o1, o3, dut3.state} !== {e.e1, e.e3, e.st3}) begin
        n_err++;
        $display("FAIL forwarding[%0d]: got %b %b st3=%0d, expected %b %b st3=%0d", i, o1, o3, dut3.state, e.e1, e.e3, e.st3);
      end
    end
  endtask

  task automatic test_branch();
    step_t t[$];
    step_t e;
    in_t s;
    do_reset();
    s = idle(); s.br = 1'b1;
    t.push_back('{s, eo(0,0,1,0,2'b00,2'b00), eo(0,0,1,0,2'b00,2'b00), RUN});
    t.push_back('{with_hz(s, 5'd3), eo(1,1,0,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), RUN});
    t.push_back('{s, eo(0,0,1,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), LD_STALL});
    t.push_back('{idle(), eo(0,0,0,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), LD_STALL});
    t.push_back('{s, eo(0,0,1,0,2'b00,2'b00), eo(0,0,1,0,2'b00,2'b00), RUN});
    t.push_back('{idle(), eo(0,0,0,0,2'b00,2'b00), eo(0,0,0,0,2'b00,2'b00), RUN});
    foreach (t[i]) begin
      @(posedge clk); #1 din = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({o1, o3, dut3.state} !== {e.e1, e.e3, e.st3}) begin
        n_err++;
        $display("FAIL branch[%0d]: got %b %b st3=%0d, expected %b %b st3=%0d", i, o1, o3, dut3.state, e.e1, e.e3, e.st3);
      end
    end
    n_checks++;
    if ({sc1, fc1, sc3, fc3} !== {(PERF ? 16'd1 : 16'd0), (PERF ? 16'd3 : 16'd0),
                                  (PERF ? 16'd3 : 16'd0), (PERF ? 16'd2 : 16'd0)}) begin
      n_err++;
      $display("FAIL branch_cnt: got stall %0d/%0d flush %0d/%0d, perf=%0d expects stall 1/3 flush 3/2", sc1, sc3, fc1, fc3, PERF);
    end
  endtask

  task automatic test_halt();
    step_t t[$];
    step_t e;
    in_t s;
    do_reset();
    s = with_hz(idle(), 5'd6); s.h2 = 1'b1;
    t.push_back('{s, eo(1,0,0,0,2'b00,2'b00), eo(1,0,0,0,2'b00,2'b00), RUN});
    t.push_back('{idle(), eo(1,1,0,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), DRAIN});
    t.push_back('{idle(), eo(1,1,0,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), DRAIN});
    s = idle(); s.h5 = 1'b1;
    t.push_back('{s, eo(1,1,0,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), DRAIN});
    t.push_back('{idle(), eo(1,1,0,1,2'b00,2'b00), eo(1,1,0,1,2'b00,2'b00), HALTED});
    s = with_hz(idle(), 5'd6); s.h2 = 1'b1; s.br = 1'b1;
    t.push_back('{s, eo(1,1,0,1,2'b00,2'b00), eo(1,1,0,1,2'b00,2'b00), HALTED});
    t.push_back('{idle(), eo(1,1,0,1,2'b00,2'b00), eo(1,1,0,1,2'b00,2'b00), HALTED});
    foreach (t[i]) begin
      @(posedge clk); #1 din = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({o1, o3, dut3.state} !== {e.e1, e.e3, e.st3}) begin
        n_err++;
        $display("FAIL halt[%0d]: got %b %b st3=%0d, expected %b %b st3=%0d", i, o1, o3, dut3.state, e.e1, e.e3, e.st3);
      end
    end
    n_checks++;
    if ({sc1, fc1, sc3, fc3} !== {(PERF ? 16'd1 : 16'd0), 16'd0, (PERF ? 16'd1 : 16'd0), 16'd0}) begin
      n_err++;
      $display("FAIL halt_cnt: got stall %0d/%0d flush %0d/%0d, perf=%0d expects stall 1/1 flush 0/0", sc1, sc3, fc1, fc3, PERF);
    end
  endtask

  task automatic test_reset_mid_drain();
    step_t t[$];
    step_t e;
    in_t s;
    do_reset();
    s = idle(); s.h2 = 1'b1;
    t.push_back('{s, eo(1,0,0,0,2'b00,2'b00), eo(1,0,0,0,2'b00,2'b00), RUN});
    t.push_back('{idle(), eo(1,1,0,0,2'b00,2'b00), eo(1,1,0,0,2'b00,2'b00), DRAIN});
    foreach (t[i]) begin
      @(posedge clk); #1 din = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({o1, o3, dut3.state} !== {e.e1, e.e3, e.st3}) begin
        n_err++;
        $display("FAIL mid_drain[%0d]: got %b %b st3=%0d, expected %b %b st3=%0d", i, o1, o3, dut3.state, e.e1, e.e3, e.st3);
      end
    end
    #2 rst_ = 1'b0;
    #1;
    n_checks++;
    if ({o1, o3, dut3.state, dut1.state} !== {16'h0, RUN, RUN}) begin
      n_err++;
      $display("FAIL async_reset: got %b %b st3=%0d st1=%0d, expected all zero, RUN", o1, o3, dut3.state, dut1.state);
    end
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({o1, o3, dut3.state, sc1, fc1, sc3, fc3} !== {16'h0, RUN, 64'h0}) begin
      n_err++;
      $display("FAIL after_reset: got %b %b st3=%0d cnt %0d %0d %0d %0d, expected zero, RUN", o1, o3, dut3.state, sc1, fc1, sc3, fc3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    din = idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_forwarding();
    test_branch();
    test_halt();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
